// File: rtl/truth_table_scanner_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_pkg
// Shared definitions for the truth-table scanner:
//   state_t          - scanner FSM states (IDLE, DRIVE, DONE)
//   VEC_W / TBL_W    - input-vector width and truth-table width
//   CNT_W            - settle counter width (holds 0..255)
//   REF_NOT_B_AND_D  - reference table for F = ~B & D (minterms 1,3,9,11)
// ---------------------------------------------------------------------------
package truth_table_scanner_pkg;

    localparam int VEC_W = 4;
    localparam int TBL_W = 16;
    localparam int CNT_W = 8;

    localparam logic [TBL_W-1:0] REF_NOT_B_AND_D = 16'h0A0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Counts cycles a vector has been presented to the gate under test.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous clear of the count (takes priority over counting)
//   expire - high while the count equals SETTLE_CYCLES
// The owner clears the counter on the same edge it sees expire, so the count
// never climbs past SETTLE_CYCLES and no wrap handling is needed.
// ---------------------------------------------------------------------------
module settle_timer
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (clear) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (count_reg == LIMIT);

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Drives all 16 input vectors onto a 4-in/1-out gate, holds each for
// SETTLE_CYCLES+1 cycles, captures the gate output into a truth table and
// compares the table against EXPECTED.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - begin a scan (only honoured in IDLE, and only without abort)
//   abort      - cancel a running scan; keeps the partial table
//   abcd       - vector to the gate, abcd[3]=a ... abcd[0]=d
//   f_in       - gate output, sampled on the last edge of each settle window
//   busy       - high while vectors are being driven
//   done       - one-cycle completion pulse
//   table_q    - captured truth table, bit v = f_in for vector v
//   match      - table_q == EXPECTED, valid from done until the next start
//   fail_count - number of table bits differing from EXPECTED (0..16)
// ---------------------------------------------------------------------------
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned      SETTLE_CYCLES = 1,
    parameter logic [TBL_W-1:0] EXPECTED      = REF_NOT_B_AND_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] abcd,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [TBL_W-1:0] table_q,
    output logic             match,
    output logic [4:0]       fail_count
);

    state_t           state_reg;
    logic [VEC_W-1:0] abcd_reg;
    logic [TBL_W-1:0] table_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             match_reg;
    logic [4:0]       fail_count_reg;

    logic             timer_clear;
    logic             timer_expire;
    logic [TBL_W-1:0] mism;
    logic [4:0]       fail_count_next;

    // The timer only runs in DRIVE; it restarts for every vector and is held
    // at zero otherwise so each scan's first window is a full one.
    assign timer_clear = (state_reg != DRIVE) || timer_expire || abort;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    // Popcount of mismatching table bits. Evaluated in DONE, one edge after
    // the last capture, so the final bit of table_reg is already settled.
    genvar gi;
    generate
        for (gi = 0; gi < TBL_W; gi++) begin : g_mism
            assign mism[gi] = table_reg[gi] ^ EXPECTED[gi];
        end
    endgenerate

    always_comb begin
        fail_count_next = '0;
        for (int i = 0; i < TBL_W; i++) begin
            fail_count_next = fail_count_next + {4'd0, mism[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            abcd_reg       <= '0;
            table_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            match_reg      <= 1'b0;
            fail_count_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // abort wins over start when both are presented here.
                    if (start && !abort) begin
                        state_reg      <= DRIVE;
                        busy_reg       <= 1'b1;
                        abcd_reg       <= '0;
                        table_reg      <= '0;
                        match_reg      <= 1'b0;
                        fail_count_reg <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        // Partial table is kept for inspection.
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                        abcd_reg       <= '0;
                        match_reg      <= 1'b0;
                        fail_count_reg <= '0;
                    end else if (timer_expire) begin
                        table_reg[abcd_reg] <= f_in;
                        if (abcd_reg == 4'hF) begin
                            // abcd stays at 15 until the next start.
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                        end else begin
                            abcd_reg <= abcd_reg + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_reg      <= IDLE;
                    done_reg       <= 1'b1;
                    match_reg      <= (table_reg == EXPECTED);
                    fail_count_reg <= fail_count_next;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign abcd       = abcd_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign table_q    = table_reg;
    assign match      = match_reg;
    assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (S=1, S=0, S=3) share clock
// and reset. A timing model derived from edge counts since start predicts
// every output of every instance each cycle; directed scans add literal
// expectations for tables, fail counts and done latency.
module tb_truth_table_scanner;

    localparam int S_OF [3] = '{1, 0, 3};
    localparam logic [15:0] EXP_TBL = 16'h0A0A;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [2:0]  f_in_v;
    logic [2:0]  busy_o;
    logic [2:0]  done_o;
    logic [2:0]  match_o;
    logic [3:0]  abcd_o [3];
    logic [15:0] tbl_o  [3];
    logic [4:0]  fail_o [3];
    int          gate_sel [3];

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    truth_table_scanner #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .abcd(abcd_o[0]), .f_in(f_in_v[0]), .busy(busy_o[0]), .done(done_o[0]),
        .table_q(tbl_o[0]), .match(match_o[0]), .fail_count(fail_o[0]));

    truth_table_scanner #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .abcd(abcd_o[1]), .f_in(f_in_v[1]), .busy(busy_o[1]), .done(done_o[1]),
        .table_q(tbl_o[1]), .match(match_o[1]), .fail_count(fail_o[1]));

    truth_table_scanner #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .abcd(abcd_o[2]), .f_in(f_in_v[2]), .busy(busy_o[2]), .done(done_o[2]),
        .table_q(tbl_o[2]), .match(match_o[2]), .fail_count(fail_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gates under test: 0 = ~B & D, 1 = constant 0, 2 = high only on vector 5.
    function automatic logic gate_fn(input int sel, input logic [3:0] v);
        case (sel)
            0:       return (v[2] == 1'b0) && (v[0] == 1'b1);
            1:       return 1'b0;
            default: return (v == 4'd5);
        endcase
    endfunction

    always_comb begin
        f_in_v = '0;
        for (int i = 0; i < 3; i++) begin
            f_in_v[i] = gate_fn(gate_sel[i], abcd_o[i]);
        end
    end

    task automatic chk(input string name, input int inst,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, inst, $time, act, exp);
        end
    endtask

    // ---------------- timing model ----------------
    // m_k = edges elapsed since the start edge, -1 when no scan is running.
    // With p = S+1 and n the current edge index: vector n/p-1 is captured when
    // n is a multiple of p, abcd shows n/p until 15, busy holds while n < 16p,
    // and done pulses after edge 16p+1.
    int          m_k    [3];
    logic [3:0]  m_abcd [3];
    logic        m_busy [3];
    logic        m_done [3];
    logic        m_match[3];
    logic [15:0] m_tbl  [3];
    logic [4:0]  m_fail [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_k[i] <= -1; m_abcd[i] <= '0; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
                m_match[i] <= 1'b0; m_tbl[i] <= '0; m_fail[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                automatic int p = S_OF[i] + 1;
                automatic int n = m_k[i] + 1;
                m_done[i] <= 1'b0;
                if (m_k[i] < 0) begin
                    if (start_v[i] && !abort_v[i]) begin
                        m_k[i] <= 0; m_abcd[i] <= '0; m_busy[i] <= 1'b1;
                        m_tbl[i] <= '0; m_match[i] <= 1'b0; m_fail[i] <= '0;
                    end
                end else if (abort_v[i] && m_k[i] < 16 * p) begin
                    m_k[i] <= -1; m_abcd[i] <= '0; m_busy[i] <= 1'b0;
                    m_match[i] <= 1'b0; m_fail[i] <= '0;
                end else begin
                    if (n <= 16 * p && (n % p) == 0)
                        m_tbl[i][n / p - 1] <= gate_fn(gate_sel[i], 4'(n / p - 1));
                    if (n < 16 * p) m_abcd[i] <= 4'(n / p);
                    m_busy[i] <= (n < 16 * p);
                    if (n == 16 * p + 1) begin
                        m_done[i]  <= 1'b1;
                        m_match[i] <= (m_tbl[i] == EXP_TBL);
                        m_fail[i]  <= 5'($countones(m_tbl[i] ^ EXP_TBL));
                        m_k[i]     <= -1;
                    end else begin
                        m_k[i] <= n;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("abcd",       i, 16'(abcd_o[i]),  16'(m_abcd[i]));
                chk("busy",       i, 16'(busy_o[i]),  16'(m_busy[i]));
                chk("done",       i, 16'(done_o[i]),  16'(m_done[i]));
                chk("table_q",    i, tbl_o[i],        m_tbl[i]);
                chk("match",      i, 16'(match_o[i]), 16'(m_match[i]));
                chk("fail_count", i, 16'(fail_o[i]),  16'(m_fail[i]));
            end
        end
    end

    // ---------------- directed scans ----------------
    task automatic run_scan(input int i, input int sel, input int exp_cyc,
                            input logic [15:0] exp_tbl, input logic exp_match,
                            input logic [4:0] exp_fail, input bit repulse);
        int cnt;
        gate_sel[i] = sel;
        @(negedge clk); start_v[i] = 1'b1;
        @(posedge clk);                       // edge 0: start sampled
        @(negedge clk); start_v[i] = 1'b0;
        cnt = 0;
        while (!done_o[i] && cnt < 300) begin
            start_v[i] = (repulse && (cnt == 5 || cnt == 20)) ? 1'b1 : 1'b0;
            @(negedge clk);
            cnt++;
        end
        start_v[i] = 1'b0;
        $display("scan inst=%0d sel=%0d done_cycle=%0d table=%h match=%0b fail=%0d",
                 i, sel, cnt, tbl_o[i], match_o[i], fail_o[i]);
        chk("done_cycle", i, 16'(cnt), 16'(exp_cyc));
        chk("lit_table",  i, tbl_o[i], exp_tbl);
        chk("lit_match",  i, 16'(match_o[i]), 16'(exp_match));
        chk("lit_fail",   i, 16'(fail_o[i]),  16'(exp_fail));
        chk("lit_abcd15", i, 16'(abcd_o[i]),  16'd15);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit saw_done;
        start_v = '0; abort_v = '0;
        for (int i = 0; i < 3; i++) gate_sel[i] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        rst_n = 1'b1;
        chk("rst_abcd",  0, 16'(abcd_o[0]), 16'd0);
        chk("rst_busy",  0, 16'(busy_o[0]), 16'd0);
        chk("rst_table", 0, tbl_o[0], 16'h0000);
        chk("rst_fail",  0, 16'(fail_o[0]), 16'd0);
        repeat (2) @(negedge clk);

        run_scan(0, 0, 33, 16'h0A0A, 1'b1, 5'd0, 1'b0);
        run_scan(1, 1, 17, 16'h0000, 1'b0, 5'd4, 1'b0);
        run_scan(2, 2, 65, 16'h0020, 1'b0, 5'd5, 1'b0);

        // start together with abort in IDLE: ignored.
        @(negedge clk); start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
        $display("start+abort idle busy=%0b", busy_o[0]);
        chk("idle_abort_busy", 0, 16'(busy_o[0]), 16'd0);
        repeat (2) @(negedge clk);

        // start re-pulsed while busy: timing and result unchanged.
        run_scan(0, 0, 33, 16'h0A0A, 1'b1, 5'd0, 1'b1);

        // abort during vector 6 (cycles 12..13 for S=1), sampled at edge 13.
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start_v[0] = 1'b0;
        cnt = 0;
        while (cnt < 12) begin @(negedge clk); cnt++; end
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        $display("abort busy=%0b abcd=%0d table=%h", busy_o[0], abcd_o[0], tbl_o[0]);
        chk("abort_busy",  0, 16'(busy_o[0]), 16'd0);
        chk("abort_abcd",  0, 16'(abcd_o[0]), 16'd0);
        chk("abort_table", 0, tbl_o[0], 16'h000A);
        saw_done = 0;
        repeat (40) begin @(negedge clk); if (done_o[0]) saw_done = 1; end
        chk("abort_no_done", 0, 16'(saw_done), 16'd0);
        run_scan(0, 0, 33, 16'h0A0A, 1'b1, 5'd0, 1'b0);

        // asynchronous reset during vector 9 (cycles 18..19 for S=1).
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); start_v[0] = 1'b0;
        cnt = 0;
        while (cnt < 19) begin @(negedge clk); cnt++; end
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-scan abcd=%0d busy=%0b table=%h", abcd_o[0], busy_o[0], tbl_o[0]);
        chk("arst_abcd",  0, 16'(abcd_o[0]), 16'd0);
        chk("arst_busy",  0, 16'(busy_o[0]), 16'd0);
        chk("arst_table", 0, tbl_o[0], 16'h0000);
        chk("arst_match", 0, 16'(match_o[0]), 16'd0);
        chk("arst_fail2", 2, 16'(fail_o[2]), 16'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 0;
        repeat (50) begin @(negedge clk); if (done_o[0] || busy_o[0]) saw_done = 1; end
        chk("arst_no_resume", 0, 16'(saw_done), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
